tron_cpu: RTL and testbench



---
 rtl/tron_pkg.sv | 151 +++++++++++++++
 rtl/tron_controller.sv | 56 +++++
 rtl/tron_datapath.sv | 137 +++++++++++++
 rtl/tron_cpu.sv | 68 ++++++
 tb/tb_tron_cpu.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tron_pkg.sv
// Shared definitions for the tron_cpu core: encodings, flag bits,
// FSM states and small decode helpers used by controller and datapath.
package tron_pkg;

   localparam logic [3:0] OPC_RTYPE = 4'b0000;
   localparam logic [3:0] OPC_ANDI  = 4'b0001;
   localparam logic [3:0] OPC_ORI   = 4'b0010;
   localparam logic [3:0] OPC_XORI  = 4'b0011;
   localparam logic [3:0] OPC_MEM   = 4'b0100;
   localparam logic [3:0] OPC_ADDI  = 4'b0101;
   localparam logic [3:0] OPC_SHIFT = 4'b1000;
   localparam logic [3:0] OPC_SUBI  = 4'b1001;
   localparam logic [3:0] OPC_CMPI  = 4'b1011;
   localparam logic [3:0] OPC_BCOND = 4'b1100;
   localparam logic [3:0] OPC_MOVI  = 4'b1101;
   localparam logic [3:0] OPC_LUI   = 4'b1111;

   localparam logic [3:0] EXT_AND   = 4'b0001;
   localparam logic [3:0] EXT_OR    = 4'b0010;
   localparam logic [3:0] EXT_XOR   = 4'b0011;
   localparam logic [3:0] EXT_ADD   = 4'b0101;
   localparam logic [3:0] EXT_SUB   = 4'b1001;
   localparam logic [3:0] EXT_CMP   = 4'b1011;
   localparam logic [3:0] EXT_MOV   = 4'b1101;
   localparam logic [3:0] EXT_LSH   = 4'b0100;
   localparam logic [3:0] EXT_LOAD  = 4'b0000;
   localparam logic [3:0] EXT_STOR  = 4'b0100;
   localparam logic [3:0] EXT_JAL   = 4'b1000;
   localparam logic [3:0] EXT_JCOND = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_HI = 4'b0100;
   localparam logic [3:0] COND_LS = 4'b0101;
   localparam logic [3:0] COND_GT = 4'b0110;
   localparam logic [3:0] COND_LE = 4'b0111;
   localparam logic [3:0] COND_FS = 4'b1000;
   localparam logic [3:0] COND_FC = 4'b1001;
   localparam logic [3:0] COND_LO = 4'b1010;
   localparam logic [3:0] COND_HS = 4'b1011;
   localparam logic [3:0] COND_LT = 4'b1100;
   localparam logic [3:0] COND_GE = 4'b1101;
   localparam logic [3:0] COND_UC = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_L = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 4;

   typedef enum logic [1:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE
   } state_t;

   typedef enum logic [3:0] {
      OP_NOP, OP_AND, OP_OR, OP_XOR,
      OP_ADD, OP_SUB, OP_CMP, OP_MOV,
      OP_LUI, OP_LSH, OP_LSHI, OP_LOAD,
      OP_STOR, OP_JAL, OP_JCOND, OP_BCOND
   } op_t;

   function automatic op_t decode_op(input logic [15:0] ir);
      op_t        op;
      logic [3:0] ext;
      ext = ir[7:4];
      op  = OP_NOP;
      case (ir[15:12])
         OPC_RTYPE: begin
            case (ext)
               EXT_AND: op = OP_AND;
               EXT_OR:  op = OP_OR;
               EXT_XOR: op = OP_XOR;
               EXT_ADD: op = OP_ADD;
               EXT_SUB: op = OP_SUB;
               EXT_CMP: op = OP_CMP;
               EXT_MOV: op = OP_MOV;
               default: op = OP_NOP;
            endcase
         end
         OPC_ANDI:  op = OP_AND;
         OPC_ORI:   op = OP_OR;
         OPC_XORI:  op = OP_XOR;
         OPC_ADDI:  op = OP_ADD;
         OPC_SUBI:  op = OP_SUB;
         OPC_CMPI:  op = OP_CMP;
         OPC_MOVI:  op = OP_MOV;
         OPC_LUI:   op = OP_LUI;
         OPC_BCOND: op = OP_BCOND;
         OPC_SHIFT: begin
            if (ext == EXT_LSH)
               op = OP_LSH;
            else if (ext[3:1] == 3'b000)
               op = OP_LSHI;
         end
         OPC_MEM: begin
            case (ext)
               EXT_LOAD:  op = OP_LOAD;
               EXT_STOR:  op = OP_STOR;
               EXT_JAL:   op = OP_JAL;
               EXT_JCOND: op = OP_JCOND;
               default:   op = OP_NOP;
            endcase
         end
         default: op = OP_NOP;
      endcase
      return op;
   endfunction

   function automatic logic writes_back(input op_t op);
      case (op)
         OP_AND, OP_OR, OP_XOR, OP_ADD,
         OP_SUB, OP_MOV, OP_LUI, OP_LSH,
         OP_LSHI, OP_LOAD, OP_JAL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic cond_met(input logic [3:0] cond,
                                     input logic [4:0] fl);
      logic l, c, f, z, n;
      l = fl[FLAG_L];
      c = fl[FLAG_C];
      f = fl[FLAG_F];
      z = fl[FLAG_Z];
      n = fl[FLAG_N];
      case (cond)
         COND_EQ: return z;
         COND_NE: return !z;
         COND_CS: return c;
         COND_CC: return !c;
         COND_HI: return !l && !z;
         COND_LS: return l || z;
         COND_GT: return !n && !z;
         COND_LE: return n || z;
         COND_FS: return f;
         COND_FC: return !f;
         COND_LO: return l;
         COND_HS: return !l;
         COND_LT: return n;
         COND_GE: return !n;
         COND_UC: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/tron_controller.sv
// Fetch/decode/execute sequencer; owns the instruction register.
// Ports: clk, reset, instruction in; state, ir, regWrite, memWrite, mem_sel out.
module tron_controller
   import tron_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instruction,
   output state_t      state,
   output logic [15:0] ir,
   output logic        regWrite,
   output logic        memWrite,
   output logic        mem_sel
);

   state_t state_next;
   op_t    op;

   assign op = decode_op(ir);

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_FETCH;
      else
         state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset)
         ir <= '0;
      else if (state == S_FETCH)
         ir <= instruction;
   end

   always_comb begin
      state_next = S_FETCH;
      unique case (state)
         S_FETCH:   state_next = S_DECODE;
         S_DECODE:  state_next = S_EXECUTE;
         S_EXECUTE: state_next = S_FETCH;
         default:   state_next = S_FETCH;
      endcase
   end

   always_comb begin
      regWrite = 1'b0;
      memWrite = 1'b0;
      mem_sel  = 1'b0;
      if (state == S_EXECUTE) begin
         regWrite = writes_back(op);
         memWrite = (op == OP_STOR);
         mem_sel  = (op == OP_LOAD) || (op == OP_STOR);
      end
   end

endmodule

// File: rtl/tron_datapath.sv
// Register file, ALU, flag register and PC of the core.
// Ports: clk, reset, state, ir, reg_write, load_data in; pc, reg_a, reg_b, wb_data out.
module tron_datapath
   import tron_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  state_t      state,
   input  logic [15:0] ir,
   input  logic        reg_write,
   input  logic [15:0] load_data,
   output logic [15:0] pc,
   output logic [15:0] reg_a,
   output logic [15:0] reg_b,
   output logic [15:0] wb_data
);

   logic [15:0] rf [16];
   logic [15:0] imm;
   logic [15:0] flagreg;
   logic [15:0] flag_next;
   logic [15:0] pc_next;
   logic [15:0] src;
   logic [15:0] mag;
   logic [15:0] lsh;
   logic [16:0] sum;
   logic [16:0] dif;
   logic        ovf_add;
   logic        ovf_sub;
   logic        lt_s;
   logic        taken;
   op_t         op;

   assign op    = decode_op(ir);
   assign taken = cond_met(ir[11:8], flagreg[4:0]);
   assign src   = (ir[15:12] == OPC_RTYPE) ? reg_b : imm;

   always_comb begin
      sum     = {1'b0, reg_a} + {1'b0, src};
      dif     = {1'b0, reg_a} - {1'b0, src};
      ovf_add = (reg_a[15] == src[15]) && (sum[15] != reg_a[15]);
      ovf_sub = (reg_a[15] != src[15]) && (dif[15] != reg_a[15]);
      // equal signs cannot overflow, so the difference sign decides
      lt_s    = (reg_a[15] != src[15]) ? reg_a[15] : dif[15];
   end

   // Negative Rsrc means logical right shift by its magnitude.
   always_comb begin
      mag = reg_b[15] ? (16'd0 - reg_b) : reg_b;
      if (mag >= 16'd16)
         lsh = '0;
      else if (reg_b[15])
         lsh = reg_a >> mag[3:0];
      else
         lsh = reg_a << mag[3:0];
   end

   always_comb begin
      wb_data = '0;
      unique case (op)
         OP_AND:  wb_data = reg_a & src;
         OP_OR:   wb_data = reg_a | src;
         OP_XOR:  wb_data = reg_a ^ src;
         OP_ADD:  wb_data = sum[15:0];
         OP_SUB:  wb_data = dif[15:0];
         OP_MOV:  wb_data = src;
         OP_LUI:  wb_data = {ir[7:0], 8'h00};
         OP_LSH:  wb_data = lsh;
         OP_LSHI: wb_data = reg_a << ir[3:0];
         OP_LOAD: wb_data = load_data;
         OP_STOR: wb_data = reg_a;
         OP_JAL:  wb_data = pc + 16'd1;
         default: wb_data = '0;
      endcase
   end

   always_comb begin
      flag_next = flagreg;
      unique case (op)
         OP_CMP: begin
            flag_next[FLAG_Z] = (dif[15:0] == 16'd0);
            flag_next[FLAG_L] = dif[16];
            flag_next[FLAG_N] = lt_s;
            flag_next[FLAG_C] = 1'b0;
            flag_next[FLAG_F] = 1'b0;
         end
         OP_ADD: begin
            flag_next[FLAG_C] = sum[16];
            flag_next[FLAG_F] = ovf_add;
         end
         OP_SUB: begin
            flag_next[FLAG_C] = dif[16];
            flag_next[FLAG_F] = ovf_sub;
         end
         default: flag_next = flagreg;
      endcase
   end

   always_comb begin
      pc_next = pc + 16'd1;
      unique case (op)
         OP_JAL:   pc_next = reg_b;
         OP_JCOND: if (taken) pc_next = reg_b;
         OP_BCOND: if (taken) pc_next = pc + imm;
         default:  pc_next = pc + 16'd1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= '0;
         flagreg <= '0;
         reg_a   <= '0;
         reg_b   <= '0;
         imm     <= '0;
         for (int i = 0; i < 16; i++)
            rf[i] <= 16'(i);
      end else begin
         if (state == S_DECODE) begin
            reg_a <= rf[ir[11:8]];
            reg_b <= rf[ir[3:0]];
            // logical immediates are zero-extended, the rest sign-extended
            if (ir[15:14] == 2'b00)
               imm <= {8'h00, ir[7:0]};
            else
               imm <= {{8{ir[7]}}, ir[7:0]};
         end
         if (state == S_EXECUTE) begin
            pc      <= pc_next;
            flagreg <= flag_next;
            if (reg_write)
               rf[ir[11:8]] <= wb_data;
         end
      end
   end

endmodule

// File: rtl/tron_cpu.sv
// Top of the 3-cycle 16-bit core: controller, datapath and 256-word data RAM.
// Ports: clk, reset, instruction in; addressOut, busOutput out.
module tron_cpu
   import tron_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instruction,
   output logic [15:0] addressOut,
   output logic [15:0] busOutput
);

   state_t      state;
   logic [15:0] ir;
   logic        regWrite;
   logic        memWrite;
   logic        mem_sel;
   logic [15:0] regA;
   logic [15:0] reg_b;
   logic [15:0] pc;
   logic [15:0] wb_data;
   logic [15:0] load_data;
   logic [15:0] bus_q;
   logic [15:0] ram [256];

   tron_controller fsmController (
      .clk         (clk),
      .reset       (reset),
      .instruction (instruction),
      .state       (state),
      .ir          (ir),
      .regWrite    (regWrite),
      .memWrite    (memWrite),
      .mem_sel     (mem_sel)
   );

   tron_datapath UUTdatapath (
      .clk       (clk),
      .reset     (reset),
      .state     (state),
      .ir        (ir),
      .reg_write (regWrite),
      .load_data (load_data),
      .pc        (pc),
      .reg_a     (regA),
      .reg_b     (reg_b),
      .wb_data   (wb_data)
   );

   assign load_data  = ram[reg_b[7:0]];
   assign addressOut = mem_sel ? reg_b : pc;
   // live write data while it is valid, otherwise the last value shown
   assign busOutput  = (regWrite || memWrite) ? wb_data : bus_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         bus_q <= '0;
         for (int i = 0; i < 256; i++)
            ram[i] <= '0;
      end else begin
         if (regWrite || memWrite)
            bus_q <= wb_data;
         if (memWrite)
            ram[reg_b[7:0]] <= regA;
      end
   end

endmodule

// File: tb/tb_tron_cpu.sv
// Self-checking bench for tron_cpu: directed cases plus random programs
// compared against an instruction-level reference model.
module tb_tron_cpu;

   logic        clk;
   logic        reset;
   logic [15:0] instruction;
   logic [15:0] addressOut;
   logic [15:0] busOutput;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] m_r [16];
   logic [15:0] m_ram [256];
   logic [15:0] m_pc;
   logic [15:0] m_bus;
   bit m_l, m_c, m_f, m_z, m_n;

   logic [15:0] last_bus;
   logic [15:0] last_addr;
   logic        last_wr;
   logic        last_mw;

   logic [3:0] rr_ext [7] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd11, 4'd13};
   logic [3:0] sh_ext [3] = '{4'd0, 4'd1, 4'd4};

   tron_cpu dut (
      .clk         (clk),
      .reset       (reset),
      .instruction (instruction),
      .addressOut  (addressOut),
      .busOutput   (busOutput)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int sgn(input int unsigned x);
      return (x >= 32768) ? int'(x) - 65536 : int'(x);
   endfunction

   function automatic bit cond_ok(input int c);
      case (c)
         0: return m_z;
         1: return !m_z;
         2: return m_c;
         3: return !m_c;
         4: return !m_l && !m_z;
         5: return m_l || m_z;
         6: return !m_n && !m_z;
         7: return m_n || m_z;
         8: return m_f;
         9: return !m_f;
         10: return m_l;
         11: return !m_l;
         12: return m_n;
         13: return !m_n;
         14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [15:0] exp_flags();
      return {11'd0, m_n, m_z, m_f, m_c, m_l};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_r[i] = 16'(i);
      for (int i = 0; i < 256; i++) m_ram[i] = 16'd0;
      m_pc = 0; m_bus = 0;
      m_l = 0; m_c = 0; m_f = 0; m_z = 0; m_n = 0;
   endtask

   // apply one arithmetic/logic rule by its ext (or matching opcode) code
   task automatic arith(input int k, input int unsigned rd, input int unsigned src,
                        output bit wr, output int unsigned res);
      int sr;
      wr = 1; res = 0;
      case (k)
         1: res = rd & src;
         2: res = rd | src;
         3: res = rd ^ src;
         5: begin
            res = (rd + src) % 65536;
            m_c = (rd + src) > 65535;
            sr = sgn(rd) + sgn(src);
            m_f = (sr > 32767) || (sr < -32768);
         end
         9: begin
            res = (rd + 65536 - src) % 65536;
            m_c = rd < src;
            sr = sgn(rd) - sgn(src);
            m_f = (sr > 32767) || (sr < -32768);
         end
         11: begin
            wr = 0;
            m_z = (rd == src);
            m_l = (rd < src);
            m_n = (sgn(rd) < sgn(src));
            m_c = 0; m_f = 0;
         end
         13: res = src;
         default: wr = 0;
      endcase
   endtask

   task automatic model_step(input logic [15:0] ins, output bit wr,
                             output bit mw, output logic [15:0] ea);
      int op, ext, d, s, sh;
      int unsigned rd, rs, zi, si, res, npc;
      op = ins[15:12]; ext = ins[7:4]; d = ins[11:8]; s = ins[3:0];
      rd = m_r[d]; rs = m_r[s];
      zi = ins[7:0];
      si = ins[7] ? (zi | 32'hFF00) : zi;
      wr = 0; mw = 0; ea = m_pc; res = 0;
      npc = (m_pc + 1) % 65536;
      case (op)
         0: if (ext inside {1, 2, 3, 5, 9, 11, 13}) arith(ext, rd, rs, wr, res);
         1, 2, 3: arith(op, rd, zi, wr, res);
         5, 9, 11, 13: arith(op, rd, si, wr, res);
         15: begin wr = 1; res = zi * 256; end
         8: begin
            if (ext == 4) begin
               wr = 1;
               sh = sgn(rs);
               if (sh >= 16 || sh <= -16) res = 0;
               else if (sh >= 0) res = (rd << sh) % 65536;
               else res = rd >> (-sh);
            end else if (ext <= 1) begin
               wr = 1;
               res = (rd << ins[3:0]) % 65536;
            end
         end
         4: begin
            case (ext)
               0: begin wr = 1; res = m_ram[rs % 256]; ea = 16'(rs); end
               4: begin mw = 1; res = rd; ea = 16'(rs); m_ram[rs % 256] = 16'(rd); end
               8: begin wr = 1; res = npc; npc = rs; end
               12: if (cond_ok(d)) npc = rs;
               default: ;
            endcase
         end
         12: if (cond_ok(d)) npc = (m_pc + si) % 65536;
         default: ;
      endcase
      if (wr) m_r[d] = 16'(res);
      if (wr || mw) m_bus = 16'(res);
      m_pc = 16'(npc);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      instruction = 16'h0000;
      @(posedge clk); #1;
      check("rst_addr", addressOut, 16'h0000);
      check("rst_bus", busOutput, 16'h0000);
      check("rst_regwrite", dut.regWrite, 16'd0);
      check("rst_memwrite", dut.memWrite, 16'd0);
      check("rst_flags", dut.UUTdatapath.flagreg, 16'h0000);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic run_instr(input logic [15:0] ins);
      bit wr, mw;
      logic [15:0] ea, pc0;
      pc0 = m_pc;
      instruction = ins;
      check("fetch_addr", addressOut, pc0);
      @(posedge clk); #1;
      check("decode_addr", addressOut, pc0);
      @(posedge clk); #1;
      model_step(ins, wr, mw, ea);
      last_bus = busOutput; last_addr = addressOut;
      last_wr = dut.regWrite; last_mw = dut.memWrite;
      check("exec_regwrite", dut.regWrite, 16'(wr));
      check("exec_memwrite", dut.memWrite, 16'(mw));
      check("exec_bus", busOutput, m_bus);
      check("exec_addr", addressOut, ea);
      @(posedge clk); #1;
      check("flags", dut.UUTdatapath.flagreg, exp_flags());
   endtask

   function automatic logic [15:0] rand_ins();
      logic [15:0] w;
      w = 16'($urandom);
      case (w[15:12])
         4'h0: w[7:4] = rr_ext[$urandom_range(0, 6)];
         4'h4: w[7:4] = {w[5:4], 2'b00};
         4'h8: w[7:4] = sh_ext[$urandom_range(0, 2)];
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      reset = 1'b1;
      instruction = 16'h0000;
      model_reset();
      @(posedge clk); #1;

      do_reset();
      run_instr(16'h0152);
      check("add_addr", last_addr, 16'h0000);
      check("add_wr", 16'(last_wr), 16'd1);
      check("add_bus", last_bus, 16'h0003);

      do_reset();
      run_instr(16'h5193);
      check("addi_bus", last_bus, 16'hFF94);
      do_reset();
      run_instr(16'h0192);
      check("sub_bus", last_bus, 16'hFFFF);
      do_reset();
      run_instr(16'hF101);
      check("lui_bus", last_bus, 16'h0100);

      do_reset();
      run_instr(16'h01B1);
      check("cmp_wr", 16'(last_wr), 16'd0);
      check("cmp_flags", dut.UUTdatapath.flagreg, 16'h0008);
      run_instr(16'hB102);
      check("cmpi_flags", dut.UUTdatapath.flagreg, 16'h0011);

      do_reset();
      run_instr(16'h8143);
      check("lsh_bus", last_bus, 16'h0008);
      do_reset();
      run_instr(16'h8101);
      check("lshi_bus", last_bus, 16'h0002);
      do_reset();
      run_instr(16'h8111);
      check("lshi_b4_bus", last_bus, 16'h0002);

      do_reset();
      run_instr(16'hD2FF);
      run_instr(16'h8442);
      check("lsh_right", last_bus, 16'h0002);
      run_instr(16'hD310);
      run_instr(16'h8543);
      check("lsh_16", last_bus, 16'h0000);
      run_instr(16'hD6F0);
      run_instr(16'h8746);
      check("lsh_m16", last_bus, 16'h0000);

      do_reset();
      run_instr(16'h01B1);
      run_instr(16'h40C1);
      check("jeq_target", addressOut, 16'h0001);
      run_instr(16'hCE03);
      check("buc_target", addressOut, 16'h0004);

      do_reset();
      run_instr(16'h4541);
      check("stor_mw", 16'(last_mw), 16'd1);
      check("stor_bus", last_bus, 16'h0005);
      check("stor_addr", last_addr, 16'h0001);
      run_instr(16'h4101);
      check("load_wr", 16'(last_wr), 16'd1);
      check("load_bus", last_bus, 16'h0005);

      do_reset();
      run_instr(16'hCEFF);
      check("pc_ffff", addressOut, 16'hFFFF);
      run_instr(16'h0000);
      check("pc_wrap", addressOut, 16'h0000);

      do_reset();
      instruction = 16'h0152;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort_exec_wr", dut.regWrite, 16'd1);
      do_reset();
      run_instr(16'h0152);
      check("after_abort", last_bus, 16'h0003);

      do_reset();
      for (int i = 0; i < 600; i++)
         run_instr(rand_ins());

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
